// File: rtl/fetch_decode.sv
// Instruction fetch/decode sequencer: fetches a word via MAR/MDR into ir, decodes it,
// and holds the matching execute-unit start line until that unit reports done.
module fetch_decode #(
    parameter int DATA_W       = 16,
    parameter int MEM_WAIT     = 1,
    parameter int EXEC_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              exec_done,
    output logic              pc_out_en,
    output logic              MARin,
    output logic              EN,
    output logic              RW,
    output logic              MDR_tobusin,
    output logic              IRin,
    output logic              pc_inc,
    output logic              start_load,
    output logic              start_store,
    output logic              start_alu,
    output logic [3:0]        alu_op,
    output logic [5:0]        parameter1,
    output logic [5:0]        parameter2,
    output logic              donefetch,
    output logic              halted,
    output logic              illegal,
    output logic              exec_timeout
);

    typedef enum logic [2:0] {
        IDLE, PCOUT, MEMRD, IRLD, PCINC, EXEC, CLEAR, HALT
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
    localparam logic [7:0] EXEC_LAST = 8'(EXEC_TIMEOUT - 1);

    state_t            state, next;
    logic [DATA_W-1:0] ir;
    logic [3:0]        wait_cnt;
    logic [7:0]        exec_cnt;
    logic              illegal_flag, timeout_flag, timeout_hit;
    logic              op_nop, op_load, op_store, op_alu, op_halt, op_bad;
    logic [3:0]        opcode;

    assign opcode     = ir[15:12];
    assign alu_op     = opcode;
    assign parameter1 = ir[11:6];
    assign parameter2 = ir[5:0];

    always_comb begin
        op_nop   = (opcode == 4'h0);
        op_load  = (opcode == 4'h1);
        op_store = (opcode == 4'h2);
        op_alu   = (opcode[3:2] == 2'b01);
        op_halt  = (opcode == 4'hF);
        op_bad   = !(op_nop || op_load || op_store || op_alu || op_halt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ir           <= '0;
            wait_cnt     <= '0;
            exec_cnt     <= '0;
            illegal_flag <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= next;
            // Counters idle at zero outside their state so every entry starts fresh.
            wait_cnt <= (state == MEMRD) ? wait_cnt + 4'd1 : '0;
            exec_cnt <= (state == EXEC)  ? exec_cnt + 8'd1 : '0;
            if (state == IRLD)
                ir <= bus_in;
            if (state == PCINC && op_bad)
                illegal_flag <= 1'b1;
            if (timeout_hit)
                timeout_flag <= 1'b1;
        end
    end

    always_comb begin
        next        = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (run) next = PCOUT;
            PCOUT: next = MEMRD;
            MEMRD: if (wait_cnt == WAIT_LAST) next = IRLD;
            IRLD:  next = PCINC;
            PCINC: begin
                if (op_load || op_store || op_alu) next = EXEC;
                else if (op_halt)                  next = HALT;
                else                               next = run ? PCOUT : IDLE;
            end
            EXEC: begin
                if (exec_done) begin
                    next = CLEAR;
                end else if (exec_cnt == EXEC_LAST) begin
                    next        = CLEAR;
                    timeout_hit = 1'b1;
                end
            end
            CLEAR:   next = run ? PCOUT : IDLE;
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        pc_out_en    = (state == PCOUT);
        MARin        = (state == PCOUT);
        EN           = (state == MEMRD);
        RW           = (state == MEMRD);
        MDR_tobusin  = (state == IRLD);
        IRin         = (state == IRLD);
        pc_inc       = (state == PCINC);
        start_load   = (state == EXEC) && op_load;
        start_store  = (state == EXEC) && op_store;
        start_alu    = (state == EXEC) && op_alu;
        donefetch    = (state == CLEAR);
        halted       = (state == HALT);
        illegal      = illegal_flag;
        exec_timeout = timeout_flag;
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: cycle table for fetch/LOAD/NOP/HALT, plus hand
// sequences for halt hold, illegal opcodes, watchdog, run drop and async reset.
module tb_fetch_decode;

    localparam logic [13:0] S_IDLE  = 14'h0000;
    localparam logic [13:0] S_PCOUT = 14'h3000;
    localparam logic [13:0] S_MEMRD = 14'h0C00;
    localparam logic [13:0] S_IRLD  = 14'h0300;
    localparam logic [13:0] S_PCINC = 14'h0080;
    localparam logic [13:0] S_LOAD  = 14'h0040;
    localparam logic [13:0] S_STORE = 14'h0020;
    localparam logic [13:0] S_ALU   = 14'h0010;
    localparam logic [13:0] S_CLR   = 14'h0008;
    localparam logic [13:0] S_HALT  = 14'h0004;
    localparam logic [13:0] F_ILL   = 14'h0002;
    localparam logic [13:0] F_TO    = 14'h0001;

    typedef struct {
        logic        run;
        logic [15:0] bus;
        logic        done;
        logic [13:0] exp;
        logic [5:0]  p1;
        logic [5:0]  p2;
        logic [3:0]  aop;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, run_a = 1'b0, done_a = 1'b0;
    logic [15:0] bus_a = '0;
    logic        pc_a, mar_a, en_a, rw_a, mdr_a, ir_a, inc_a, ld_a, st_a, alu_a;
    logic        df_a, halt_a, ill_a, to_a;
    logic [3:0]  aop_a;
    logic [5:0]  p1_a, p2_a;
    logic [13:0] obs_a;

    logic        rst_b = 1'b1, run_b = 1'b0, done_b = 1'b0;
    logic [15:0] bus_b = '0;
    logic        pc_b, mar_b, en_b, rw_b, mdr_b, ir_b, inc_b, ld_b, st_b, alu_b;
    logic        df_b, halt_b, ill_b, to_b;
    logic [3:0]  aop_b;
    logic [5:0]  p1_b, p2_b;
    logic [13:0] obs_b;

    assign obs_a = {pc_a, mar_a, en_a, rw_a, mdr_a, ir_a, inc_a, ld_a, st_a, alu_a,
                    df_a, halt_a, ill_a, to_a};
    assign obs_b = {pc_b, mar_b, en_b, rw_b, mdr_b, ir_b, inc_b, ld_b, st_b, alu_b,
                    df_b, halt_b, ill_b, to_b};

    fetch_decode #(.DATA_W(16), .MEM_WAIT(1), .EXEC_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst_a), .run(run_a), .bus_in(bus_a), .exec_done(done_a),
        .pc_out_en(pc_a), .MARin(mar_a), .EN(en_a), .RW(rw_a), .MDR_tobusin(mdr_a),
        .IRin(ir_a), .pc_inc(inc_a), .start_load(ld_a), .start_store(st_a),
        .start_alu(alu_a), .alu_op(aop_a), .parameter1(p1_a), .parameter2(p2_a),
        .donefetch(df_a), .halted(halt_a), .illegal(ill_a), .exec_timeout(to_a)
    );

    fetch_decode #(.DATA_W(16), .MEM_WAIT(3), .EXEC_TIMEOUT(255)) dut_b (
        .clk(clk), .rst(rst_b), .run(run_b), .bus_in(bus_b), .exec_done(done_b),
        .pc_out_en(pc_b), .MARin(mar_b), .EN(en_b), .RW(rw_b), .MDR_tobusin(mdr_b),
        .IRin(ir_b), .pc_inc(inc_b), .start_load(ld_b), .start_store(st_b),
        .start_alu(alu_b), .alu_op(aop_b), .parameter1(p1_b), .parameter2(p2_b),
        .donefetch(df_b), .halted(halt_b), .illegal(ill_b), .exec_timeout(to_b)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t        tbl[19];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [15:0] b, input logic d,
                                input logic [13:0] e, input logic [5:0] p1,
                                input logic [5:0] p2, input logic [3:0] a);
        vec_t v;
        v.run = r; v.bus = b; v.done = d; v.exp = e; v.p1 = p1; v.p2 = p2; v.aop = a;
        return v;
    endfunction

    // Starts in PCOUT of dut_a (MEM_WAIT=1); ends one cycle after PCINC.
    task automatic fetch_a(input logic [15:0] w, input logic [13:0] fl);
        chk("f_pcout", 16'(obs_a), 16'(S_PCOUT | fl)); step();
        chk("f_memrd", 16'(obs_a), 16'(S_MEMRD | fl)); step();
        chk("f_irld",  16'(obs_a), 16'(S_IRLD  | fl));
        bus_a = w; step(); bus_a = '0;
        chk("f_pcinc", 16'(obs_a), 16'(S_PCINC | fl)); step();
    endtask

    task automatic reset_a();
        rst_a = 1'b0; #1;
        rst_a = 1'b1; run_a = 1'b1; done_a = 1'b0;
        step();
    endtask

    initial begin
        tbl[0]  = mk(1, 16'h0000, 0, S_IDLE,  6'h00, 6'h00, 4'h0);
        tbl[1]  = mk(1, 16'h0000, 0, S_PCOUT, 6'h00, 6'h00, 4'h0);
        tbl[2]  = mk(1, 16'h0000, 0, S_MEMRD, 6'h00, 6'h00, 4'h0);
        tbl[3]  = mk(1, 16'h1143, 0, S_IRLD,  6'h00, 6'h00, 4'h0);
        tbl[4]  = mk(1, 16'h0000, 0, S_PCINC, 6'h05, 6'h03, 4'h1);
        tbl[5]  = mk(1, 16'h0000, 0, S_LOAD,  6'h05, 6'h03, 4'h1);
        tbl[6]  = mk(1, 16'h0000, 0, S_LOAD,  6'h05, 6'h03, 4'h1);
        tbl[7]  = mk(1, 16'h0000, 0, S_LOAD,  6'h05, 6'h03, 4'h1);
        tbl[8]  = mk(1, 16'h0000, 1, S_LOAD,  6'h05, 6'h03, 4'h1);
        tbl[9]  = mk(1, 16'h0000, 0, S_CLR,   6'h05, 6'h03, 4'h1);
        tbl[10] = mk(1, 16'h0000, 0, S_PCOUT, 6'h05, 6'h03, 4'h1);
        tbl[11] = mk(1, 16'h0000, 0, S_MEMRD, 6'h05, 6'h03, 4'h1);
        tbl[12] = mk(1, 16'h0000, 0, S_IRLD,  6'h05, 6'h03, 4'h1);
        tbl[13] = mk(1, 16'h0000, 0, S_PCINC, 6'h00, 6'h00, 4'h0);
        tbl[14] = mk(1, 16'h0000, 0, S_PCOUT, 6'h00, 6'h00, 4'h0);
        tbl[15] = mk(1, 16'h0000, 0, S_MEMRD, 6'h00, 6'h00, 4'h0);
        tbl[16] = mk(1, 16'hF000, 0, S_IRLD,  6'h00, 6'h00, 4'h0);
        tbl[17] = mk(1, 16'h0000, 0, S_PCINC, 6'h00, 6'h00, 4'hF);
        tbl[18] = mk(1, 16'h0000, 0, S_HALT,  6'h00, 6'h00, 4'hF);

        #1 rst_a = 1'b0; rst_b = 1'b0;
        step(); step();
        chk("rst_outs", 16'(obs_a), 16'(S_IDLE));
        chk("rst_p1",   16'(p1_a), 16'h0);
        chk("rst_aop",  16'(aop_a), 16'h0);
        rst_a = 1'b1;
        step();

        // LOAD 0x1143, NOP, HALT
        for (int i = 0; i < 19; i++) begin
            run_a = tbl[i].run; bus_a = tbl[i].bus; done_a = tbl[i].done;
            chk($sformatf("tbl%0d_outs", i), 16'(obs_a), 16'(tbl[i].exp));
            chk($sformatf("tbl%0d_p1",   i), 16'(p1_a),  16'(tbl[i].p1));
            chk($sformatf("tbl%0d_p2",   i), 16'(p2_a),  16'(tbl[i].p2));
            chk($sformatf("tbl%0d_aop",  i), 16'(aop_a), 16'(tbl[i].aop));
            step();
        end
        done_a = 1'b0; bus_a = '0;

        for (int i = 0; i < 100; i++) begin
            chk($sformatf("halt_hold%0d", i), 16'(obs_a), 16'(S_HALT));
            step();
        end
        rst_a = 1'b0; #1;
        chk("halt_rst_outs", 16'(obs_a), 16'(S_IDLE));
        chk("halt_rst_aop",  16'(aop_a), 16'h0);

        // illegal opcode 0x3, sticky through two more instructions
        reset_a();
        fetch_a(16'h3000, S_IDLE);
        fetch_a(16'h0000, F_ILL);
        fetch_a(16'h0000, F_ILL);
        chk("ill_sticky", 16'(obs_a), 16'(S_PCOUT | F_ILL));

        // watchdog: exec_done never asserted
        reset_a();
        fetch_a(16'h1000, S_IDLE);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_load%0d", i), 16'(obs_a), 16'(S_LOAD));
            step();
        end
        chk("to_clear", 16'(obs_a), 16'(S_CLR | F_TO)); step();
        chk("to_next",  16'(obs_a), 16'(S_PCOUT | F_TO));

        // exec_done on the final permitted cycle beats the watchdog
        reset_a();
        fetch_a(16'h1000, S_IDLE);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dw_load%0d", i), 16'(obs_a), 16'(S_LOAD));
            if (i == 7) done_a = 1'b1;
            step();
        end
        done_a = 1'b0;
        chk("dw_clear", 16'(obs_a), 16'(S_CLR)); step();
        chk("dw_next",  16'(obs_a), 16'(S_PCOUT));

        // STORE, then ALU 0x5 with run dropped during EXEC
        fetch_a(16'h2000, S_IDLE);
        chk("st_exec", 16'(obs_a), 16'(S_STORE));
        done_a = 1'b1; step(); done_a = 1'b0;
        chk("st_clear", 16'(obs_a), 16'(S_CLR)); step();
        fetch_a(16'h5123, S_IDLE);
        chk("alu_exec0", 16'(obs_a), 16'(S_ALU));
        chk("alu_op0",   16'(aop_a), 16'h5); step();
        run_a = 1'b0;
        chk("alu_exec1", 16'(obs_a), 16'(S_ALU)); step();
        chk("alu_exec2", 16'(obs_a), 16'(S_ALU));
        chk("alu_op2",   16'(aop_a), 16'h5);
        done_a = 1'b1; step(); done_a = 1'b0;
        chk("alu_clear", 16'(obs_a), 16'(S_CLR));
        chk("alu_op_cl", 16'(aop_a), 16'h5); step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("alu_idle%0d", i), 16'(obs_a), 16'(S_IDLE));
            step();
        end
        chk("alu_op_hold", 16'(aop_a), 16'h5);
        chk("alu_p1",      16'(p1_a),  16'h04);
        chk("alu_p2",      16'(p2_a),  16'h23);

        // async reset in the second MEM_WAIT cycle of dut_b
        rst_b = 1'b1; run_b = 1'b1;
        step();
        chk("b_pcout", 16'(obs_b), 16'(S_PCOUT)); step();
        chk("b_memrd1", 16'(obs_b), 16'(S_MEMRD)); step();
        chk("b_memrd2", 16'(obs_b), 16'(S_MEMRD));
        #2 rst_b = 1'b0; #1;
        chk("b_async_rst", 16'(obs_b), 16'(S_IDLE));
        step();
        rst_b = 1'b1;
        step();
        chk("b_re_pcout", 16'(obs_b), 16'(S_PCOUT)); step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b_re_memrd%0d", i), 16'(obs_b), 16'(S_MEMRD));
            step();
        end
        chk("b_re_irld", 16'(obs_b), 16'(S_IRLD));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
Instruction fetch/decode sequencer sitting directly upstream of the load execute FSM (and sibling execute units).
- Fetch: drives PC onto the bus into MAR, performs a memory read, and latches the MDR word into its instruction register.
- Decode and dispatch: increments PC, splits the instruction into opcode/parameter1/parameter2, and holds the matching start line until the unit reports done.
- Clear: pulses donefetch to return execute FSMs to their reset state before the next fetch.

Parameters:
DATA_W, 16, instruction/bus width; opcode = ir[15:12], parameter1 = ir[11:6], parameter2 = ir[5:0].
MEM_WAIT, 1, cycles EN/RW held in memory-read state (legal 1..15).
EXEC_TIMEOUT, 255, max cycles in EXEC without exec_done before forced abort (legal 1..255).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
run  in  1  level; high = keep fetching instructions.
bus_in  in  DATA_W  shared data bus (MDR contents when MDR_tobusin high).
exec_done  in  1  done from the active execute unit (load FSM done).
pc_out_en  out  1  PC drives bus.
MARin  out  1  MAR captures bus.
EN  out  1  memory enable.
RW  out  1  memory read (1 = read).
MDR_tobusin  out  1  MDR drives bus.
IRin  out  1  instruction register load strobe (also internal capture).
pc_inc  out  1  one-cycle PC increment strobe.
start_load  out  1  held start to load FSM.
start_store  out  1  held start to store FSM.
start_alu  out  1  held start to ALU FSM.
alu_op  out  4  opcode, valid while start_alu high.
parameter1  out  6  ir[11:6], registered.
parameter2  out  6  ir[5:0], registered.
donefetch  out  1  one-cycle clear pulse to execute FSMs.
halted  out  1  high in HALT.
illegal  out  1  sticky: undefined opcode seen.
exec_timeout  out  1  sticky: EXEC aborted by watchdog.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; ir, wait/timeout counters, and sticky flags cleared. Takes effect mid-instruction with no completion.
- States and outputs (Moore, decoded from state register; all strobes glitch-free from flops):
  - IDLE: all strobes 0. run high at an edge -> PCOUT.
  - PCOUT: pc_out_en = 1, MARin = 1. Next -> MEMRD.
  - MEMRD: EN = RW = 1 for exactly MEM_WAIT cycles (counter), then -> IRLD.
  - IRLD: MDR_tobusin = 1, IRin = 1; ir <= bus_in at the closing edge. Next -> PCINC.
  - PCINC: pc_inc = 1; opcode decoded from ir.
    - NOP (0x0) -> PCOUT if run else IDLE.
    - LOAD (0x1), STORE (0x2), ALU (0x4-0x7) -> EXEC.
    - HALT (0xF) -> HALT.
    - Others: set illegal; treat as NOP.
  - EXEC: matching start_* held high every cycle. Counter increments each cycle.
    - exec_done sampled high -> CLEAR.
    - Else counter == EXEC_TIMEOUT-1 -> set exec_timeout, -> CLEAR.
    - exec_done and timeout in same cycle: done wins, flag not set.
  - CLEAR: donefetch = 1 for exactly one cycle, start_* = 0. Next -> PCOUT if run else IDLE.
  - HALT: halted = 1, all strobes 0. Exit only via reset.
- Register hold: parameter1/parameter2/alu_op hold from the edge closing IRLD until the next IRLD.
- run low mid-instruction: current instruction completes (through CLEAR or NOP decode), then IDLE. run is not sampled elsewhere.
- Exclusivity: at most one of pc_out_en, MDR_tobusin drives the bus in any cycle; never both.
- Latency: run rising -> pc_out_en high 1 cycle later. NOP instruction = 3 + MEM_WAIT cycles.

Test Plan:
1. MEM_WAIT=1, run=1, bus_in=0x1143 during IRLD:
   - Expected: pc_out_en cycle 1, EN/RW cycle 2, IRin cycle 3, pc_inc cycle 4.
   - start_load high from cycle 5, parameter1=0x05, parameter2=0x03.
   - exec_done at cycle 8 -> donefetch single pulse at cycle 9, start_load low at cycle 9, pc_out_en at cycle 10.
2. bus_in=0x0000 (NOP) with run=1, then 0xF000:
   - NOP: no start_*, no donefetch; next pc_out_en 4 cycles after the previous one.
   - HALT: halted=1 held for 100 cycles, no strobes; rst low -> halted=0.
3. Opcode 0x3 fetched: illegal=1 and stays 1 through the next 2 instructions; no start_* asserted.
4. EXEC_TIMEOUT=8, LOAD with exec_done never asserted:
   - start_load high exactly 8 cycles, exec_timeout=1, one donefetch pulse.
   - Repeat with exec_done in the 8th cycle: exec_timeout stays 0.
5. rst low asynchronously mid-MEMRD (MEM_WAIT=3, second wait cycle): all outputs 0 before the next clk edge; after release with run=1, fetch restarts at PCOUT.
6. run dropped during EXEC of ALU op 0x5: alu_op=0x5 held until exec_done, CLEAR pulse, then IDLE; no pc_out_en afterwards.
